// File: rtl/operand_collector_unit_if.sv
// operand_collector_unit_if: issue, register-file, scheduler and dispatch signals of one collector slot
interface operand_collector_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WARP_ID_WIDTH  = 2
);
  logic                      Issue_Valid_IB_OC;
  logic                      OC_Free_OC_IB;
  logic [WARP_ID_WIDTH-1:0]  Warp_ID_IB_OC;
  logic [REG_ADDR_WIDTH-1:0] Rs_IB_OC;
  logic [REG_ADDR_WIDTH-1:0] Rt_IB_OC;
  logic [REG_ADDR_WIDTH-1:0] Rd_IB_OC;
  logic                      Rs_Used_IB_OC;
  logic                      Rt_Used_IB_OC;
  logic                      RegWrite_IB_OC;
  logic                      MemRead_IB_OC;
  logic                      MemWrite_IB_OC;
  logic [1:0]                RF_Req_OC_RF;
  logic [REG_ADDR_WIDTH-1:0] RF_Addr_Rs_OC_RF;
  logic [REG_ADDR_WIDTH-1:0] RF_Addr_Rt_OC_RF;
  logic [1:0]                RF_Grt_RF_OC;
  logic [DATA_WIDTH-1:0]     RF_Data_Rs_RF_OC;
  logic [DATA_WIDTH-1:0]     RF_Data_Rt_RF_OC;
  logic                      RDY;
  logic                      RegWrite_Collecting_Ex;
  logic                      MemRead_Collecting_Ex;
  logic                      MemWrite_Collecting_Ex;
  logic                      Grt_Sched_OC;
  logic                      Dispatch_Valid_OC_Ex;
  logic [DATA_WIDTH-1:0]     Rs_Data_OC_Ex;
  logic [DATA_WIDTH-1:0]     Rt_Data_OC_Ex;
  logic [REG_ADDR_WIDTH-1:0] Rd_OC_Ex;
  logic [WARP_ID_WIDTH-1:0]  Warp_ID_OC_Ex;

  modport master (
    output Issue_Valid_IB_OC, Warp_ID_IB_OC, Rs_IB_OC, Rt_IB_OC, Rd_IB_OC,
           Rs_Used_IB_OC, Rt_Used_IB_OC, RegWrite_IB_OC, MemRead_IB_OC, MemWrite_IB_OC,
           RF_Grt_RF_OC, RF_Data_Rs_RF_OC, RF_Data_Rt_RF_OC, Grt_Sched_OC,
    input  OC_Free_OC_IB, RF_Req_OC_RF, RF_Addr_Rs_OC_RF, RF_Addr_Rt_OC_RF, RDY,
           RegWrite_Collecting_Ex, MemRead_Collecting_Ex, MemWrite_Collecting_Ex,
           Dispatch_Valid_OC_Ex, Rs_Data_OC_Ex, Rt_Data_OC_Ex, Rd_OC_Ex, Warp_ID_OC_Ex
  );

  modport slave (
    input  Issue_Valid_IB_OC, Warp_ID_IB_OC, Rs_IB_OC, Rt_IB_OC, Rd_IB_OC,
           Rs_Used_IB_OC, Rt_Used_IB_OC, RegWrite_IB_OC, MemRead_IB_OC, MemWrite_IB_OC,
           RF_Grt_RF_OC, RF_Data_Rs_RF_OC, RF_Data_Rt_RF_OC, Grt_Sched_OC,
    output OC_Free_OC_IB, RF_Req_OC_RF, RF_Addr_Rs_OC_RF, RF_Addr_Rt_OC_RF, RDY,
           RegWrite_Collecting_Ex, MemRead_Collecting_Ex, MemWrite_Collecting_Ex,
           Dispatch_Valid_OC_Ex, Rs_Data_OC_Ex, Rt_Data_OC_Ex, Rd_OC_Ex, Warp_ID_OC_Ex
  );
endinterface

// File: rtl/operand_collector_unit.sv
// operand_collector_unit: one collector slot that gathers Rs/Rt from the banked register file and dispatches on scheduler grant
module operand_collector_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WARP_ID_WIDTH  = 2
) (
  input logic clk,
  input logic rst,
  operand_collector_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, READY} state_t;
  state_t state, stateNext;
  logic [1:0] pending, have, waitBits, req, capture, haveNext, usedIn;
  logic free, accept, dispatch;
  logic [WARP_ID_WIDTH-1:0] warpId;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
  logic regWrite, memRead, memWrite;
  logic [DATA_WIDTH-1:0] rsData, rtData;

  assign usedIn = {bus.Rt_Used_IB_OC, bus.Rs_Used_IB_OC};
  assign dispatch = (state == READY) & bus.Grt_Sched_OC;
  assign free = (state == IDLE) | dispatch;
  assign accept = free & bus.Issue_Valid_IB_OC;
  assign req = (state == COLLECT) ? pending & ~waitBits : 2'b00;
  assign capture = (state == COLLECT) ? waitBits : 2'b00;
  assign haveNext = have | capture;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= stateNext;

  // next state: a new issue wins over the return to IDLE so back-to-back issue has no bubble
  always_comb begin
    stateNext = state;
    if (accept) stateNext = (usedIn == 2'b00) ? READY : COLLECT;
    else if (dispatch) stateNext = IDLE;
    else if (state == COLLECT && haveNext == 2'b11) stateNext = READY;
  end

  // issue latch and per-operand request/wait/capture tracking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending  <= '0;
      have     <= '0;
      waitBits <= '0;
      warpId   <= '0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      regWrite <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      rsData   <= '0;
      rtData   <= '0;
    end else if (accept) begin
      pending  <= usedIn;
      have     <= ~usedIn;
      waitBits <= '0;
      warpId   <= bus.Warp_ID_IB_OC;
      rs       <= bus.Rs_IB_OC;
      rt       <= bus.Rt_IB_OC;
      rd       <= bus.Rd_IB_OC;
      regWrite <= bus.RegWrite_IB_OC;
      memRead  <= bus.MemRead_IB_OC;
      memWrite <= bus.MemWrite_IB_OC;
      rsData   <= '0;
      rtData   <= '0;
    end else if (state == COLLECT) begin
      waitBits <= (waitBits | (req & bus.RF_Grt_RF_OC)) & ~capture;
      pending  <= pending & ~capture;
      have     <= haveNext;
      rsData   <= capture[0] ? bus.RF_Data_Rs_RF_OC : rsData;
      rtData   <= capture[1] ? bus.RF_Data_Rt_RF_OC : rtData;
    end

  assign bus.OC_Free_OC_IB          = free;
  assign bus.RF_Req_OC_RF           = req;
  assign bus.RF_Addr_Rs_OC_RF       = rs;
  assign bus.RF_Addr_Rt_OC_RF       = rt;
  assign bus.RDY                    = state == READY;
  assign bus.RegWrite_Collecting_Ex = regWrite & (state != IDLE);
  assign bus.MemRead_Collecting_Ex  = memRead & (state != IDLE);
  assign bus.MemWrite_Collecting_Ex = memWrite & (state != IDLE);
  assign bus.Dispatch_Valid_OC_Ex   = dispatch;
  assign bus.Rs_Data_OC_Ex          = rsData;
  assign bus.Rt_Data_OC_Ex          = rtData;
  assign bus.Rd_OC_Ex               = rd;
  assign bus.Warp_ID_OC_Ex          = warpId;
endmodule
